// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache line arbiter onto a shared L2 port
// Optional round-robin arbitration between the two sides: `define MEM_ARBITER_RR_EN
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   d_req;
    logic   i_wins;

    assign d_req = dcache_read | dcache_write;

`ifdef MEM_ARBITER_RR_EN
    // prio_i set means the instruction side wins the next simultaneous request
    logic prio_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_i <= 1'b1;
        end else if (l2_resp && state == SERVE_I) begin
            prio_i <= 1'b0;
        end else if (l2_resp && state == SERVE_D) begin
            prio_i <= 1'b1;
        end
    end

    assign i_wins = prio_i;
`else
    assign i_wins = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (icache_read && d_req) begin
                    state_next = i_wins ? SERVE_I : SERVE_D;
                end else if (icache_read) begin
                    state_next = SERVE_I;
                end else if (d_req) begin
                    state_next = SERVE_D;
                end
            end
            SERVE_I: if (l2_resp) state_next = IDLE;
            SERVE_D: if (l2_resp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs follow the state; a dropped request keeps the grant until l2_resp
    always_comb begin
        l2_read      = 1'b0;
        l2_write     = 1'b0;
        l2_address   = '0;
        l2_wdata     = '0;
        icache_rdata = '0;
        dcache_rdata = '0;
        icache_resp  = 1'b0;
        dcache_resp  = 1'b0;
        case (state)
            SERVE_I: begin
                l2_read      = 1'b1;
                l2_address   = icache_address;
                icache_rdata = l2_rdata;
                icache_resp  = l2_resp;
            end
            SERVE_D: begin
                l2_read      = dcache_read & ~dcache_write;
                l2_write     = dcache_write;
                l2_address   = dcache_address;
                l2_wdata     = dcache_wdata;
                dcache_rdata = l2_rdata;
                dcache_resp  = l2_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              icache_read;
    logic [ADDR_W-1:0] icache_address;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [LINE_W-1:0] LINE_A5 = {16{8'hA5}};
    localparam logic [LINE_W-1:0] LINE_WD = {2{64'h0123456789ABCDEF}};
    localparam logic [LINE_W-1:0] LINE_3C = {16{8'h3C}};

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        icache_read = 0; icache_address = '0;
        dcache_read = 0; dcache_write = 0; dcache_address = '0; dcache_wdata = '0;
        l2_rdata = '0; l2_resp = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 0;
        #3;
        n_checks++; if ({l2_read, l2_write, icache_resp, dcache_resp} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 0000", {l2_read, l2_write, icache_resp, dcache_resp}); end
        n_checks++; if (l2_address !== 16'h0 || l2_wdata !== '0) begin
            n_fail++; $display("FAIL reset_addr_wdata got %h/%h want 0/0", l2_address, l2_wdata); end
        step();
        rst_n = 1;
        step();
        n_checks++; if ({l2_read, l2_write} !== 2'b00) begin
            n_fail++; $display("FAIL reset_idle got %b want 00", {l2_read, l2_write}); end
    endtask

    task automatic test_icache_read;
        do_reset();
        icache_read = 1; icache_address = 16'h1230;
        #1;
        n_checks++; if (l2_read !== 1'b0) begin
            n_fail++; $display("FAIL i_cycle0_l2_read got %b want 0", l2_read); end
        step();
        n_checks++; if (l2_read !== 1'b1 || l2_write !== 1'b0 || l2_address !== 16'h1230) begin
            n_fail++; $display("FAIL i_cycle1 got rd=%b wr=%b addr=%h want 1 0 1230", l2_read, l2_write, l2_address); end
        n_checks++; if (icache_resp !== 1'b0) begin
            n_fail++; $display("FAIL i_early_resp got %b want 0", icache_resp); end
        step();
        n_checks++; if (l2_read !== 1'b1) begin
            n_fail++; $display("FAIL i_cycle2_l2_read got %b want 1", l2_read); end
        step();
        l2_resp = 1; l2_rdata = LINE_A5;
        #1;
        n_checks++; if (icache_resp !== 1'b1 || icache_rdata !== LINE_A5) begin
            n_fail++; $display("FAIL i_resp got %b %h want 1 %h", icache_resp, icache_rdata, LINE_A5); end
        n_checks++; if (dcache_resp !== 1'b0 || dcache_rdata !== '0) begin
            n_fail++; $display("FAIL i_other_side got %b %h want 0 0", dcache_resp, dcache_rdata); end
        step();
        l2_resp = 0; icache_read = 0;
        #1;
        n_checks++; if (l2_read !== 1'b0 || icache_resp !== 1'b0) begin
            n_fail++; $display("FAIL i_back_idle got rd=%b resp=%b want 0 0", l2_read, icache_resp); end
    endtask

    task automatic test_dcache_write(input logic with_read);
        do_reset();
        dcache_write = 1; dcache_read = with_read;
        dcache_address = 16'h4000; dcache_wdata = LINE_WD;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++; if (l2_write !== 1'b1 || l2_read !== 1'b0) begin
                n_fail++; $display("FAIL d_wr_ctrl rdboth=%b cyc=%0d got wr=%b rd=%b want 1 0", with_read, c, l2_write, l2_read); end
            n_checks++; if (l2_wdata !== LINE_WD || l2_address !== 16'h4000) begin
                n_fail++; $display("FAIL d_wr_data got %h @%h want %h @4000", l2_wdata, l2_address, LINE_WD); end
        end
        l2_resp = 1;
        #1;
        n_checks++; if (dcache_resp !== 1'b1 || icache_resp !== 1'b0 || l2_write !== 1'b1 || l2_read !== 1'b0) begin
            n_fail++; $display("FAIL d_wr_resp got dresp=%b iresp=%b wr=%b rd=%b want 1 0 1 0", dcache_resp, icache_resp, l2_write, l2_read); end
        step();
        l2_resp = 0; dcache_write = 0; dcache_read = 0;
        #1;
        n_checks++; if (dcache_resp !== 1'b0 || l2_write !== 1'b0) begin
            n_fail++; $display("FAIL d_wr_idle got resp=%b wr=%b want 0 0", dcache_resp, l2_write); end
    endtask

    task automatic test_priority;
        string got;
        string want;
        bit    granted;
        do_reset();
        got = "";
`ifdef MEM_ARBITER_RR_EN
        want = "IDID";
`else
        want = "DDDD";
`endif
        icache_read = 1; icache_address = 16'h1111;
        dcache_read = 1; dcache_address = 16'h2222;
        l2_rdata = LINE_3C;
        for (int g = 0; g < 4; g++) begin
            granted = 0;
            for (int k = 0; k < 5 && !granted; k++) begin
                step();
                granted = l2_read | l2_write;
            end
            if (!granted) begin
                n_checks++; n_fail++;
                $display("FAIL prio_grant_timeout grant=%0d got none want a grant", g);
            end else begin
                step();
                l2_resp = 1;
                #1;
                if (l2_address == 16'h1111) begin
                    got = {got, "I"};
                    n_checks++; if (icache_resp !== 1'b1 || dcache_resp !== 1'b0 || icache_rdata !== LINE_3C) begin
                        n_fail++; $display("FAIL prio_i_resp got %b%b want 10", icache_resp, dcache_resp); end
                end else begin
                    got = {got, "D"};
                    n_checks++; if (dcache_resp !== 1'b1 || icache_resp !== 1'b0 || dcache_rdata !== LINE_3C) begin
                        n_fail++; $display("FAIL prio_d_resp got %b%b want 01", icache_resp, dcache_resp); end
                end
                step();
                l2_resp = 0;
                #1;
                n_checks++; if ({l2_read, l2_write} !== 2'b00) begin
                    n_fail++; $display("FAIL prio_idle_gap grant=%0d got %b want 00", g, {l2_read, l2_write}); end
            end
        end
        n_checks++; if (got != want) begin
            n_fail++; $display("FAIL prio_order got %s want %s", got, want); end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_serve;
        do_reset();
        dcache_write = 1; dcache_address = 16'h4000; dcache_wdata = LINE_WD;
        step();
        n_checks++; if (l2_write !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre got %b want 1", l2_write); end
        rst_n = 0; l2_resp = 1;
        #1;
        n_checks++; if (l2_write !== 1'b0 || l2_read !== 1'b0 || dcache_resp !== 1'b0 || icache_resp !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async got wr=%b rd=%b dr=%b ir=%b want 0000", l2_write, l2_read, dcache_resp, icache_resp); end
        clear_inputs();
        step();
        rst_n = 1;
        step();
        n_checks++; if (l2_write !== 1'b0 || dcache_resp !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_idle got wr=%b resp=%b want 0 0", l2_write, dcache_resp); end
    endtask

    task automatic test_idle_resp;
        do_reset();
        l2_resp = 1; l2_rdata = LINE_A5;
        #1;
        n_checks++; if (icache_resp !== 1'b0 || dcache_resp !== 1'b0 || icache_rdata !== '0 || dcache_rdata !== '0) begin
            n_fail++; $display("FAIL idle_resp_out got %b%b want 00", icache_resp, dcache_resp); end
        step();
        l2_resp = 0;
        icache_read = 1; icache_address = 16'h0040;
        step();
        n_checks++; if (l2_read !== 1'b1 || l2_address !== 16'h0040) begin
            n_fail++; $display("FAIL idle_resp_state got rd=%b addr=%h want 1 0040", l2_read, l2_address); end
        l2_resp = 1;
        step();
        clear_inputs();
    endtask

    task automatic test_drop_request;
        do_reset();
        icache_read = 1; icache_address = 16'h0800;
        step();
        icache_read = 0; dcache_read = 1; dcache_address = 16'h0900;
        step();
        n_checks++; if (l2_read !== 1'b1 || l2_address !== 16'h0800) begin
            n_fail++; $display("FAIL drop_hold got rd=%b addr=%h want 1 0800", l2_read, l2_address); end
        l2_resp = 1;
        #1;
        n_checks++; if (icache_resp !== 1'b1 || dcache_resp !== 1'b0) begin
            n_fail++; $display("FAIL drop_resp got %b%b want 10", icache_resp, dcache_resp); end
        step();
        l2_resp = 0;
        #1;
        n_checks++; if (l2_read !== 1'b0) begin
            n_fail++; $display("FAIL drop_idle got %b want 0", l2_read); end
        step();
        n_checks++; if (l2_read !== 1'b1 || l2_address !== 16'h0900) begin
            n_fail++; $display("FAIL drop_next_d got rd=%b addr=%h want 1 0900", l2_read, l2_address); end
        l2_resp = 1;
        step();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_dcache_write(1'b0);
        test_dcache_write(1'b1);
        test_priority();
        test_reset_mid_serve();
        test_idle_resp();
        test_drop_request();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got still running want finished");
        $fatal(1, "timeout");
    end
endmodule
